// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache: same-cycle hits, one outstanding
// 8-byte line fill from the memory controller's instruction port.
module instr_cache #(
    parameter int INDEX_WIDTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_signal,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic [31:0] if_instr,
    output logic        instr_signal,
    output logic [31:0] instr_a,
    input  logic [63:0] instr_d,
    input  logic        instr_done
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 32 - INDEX_WIDTH - 3;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t                   state_q, state_d;
    logic [LINES-1:0]         valid_q;
    logic [TAG_W-1:0]         tag_q  [LINES];
    logic [63:0]              data_q [LINES];

    logic [INDEX_WIDTH-1:0]   pc_idx, miss_idx;
    logic [TAG_W-1:0]         pc_tag, miss_tag;
    logic                     hit, start_miss, fill;
    logic                     unused_pc_lsbs;

    assign pc_idx         = if_pc[INDEX_WIDTH+2:3];
    assign pc_tag         = if_pc[31:INDEX_WIDTH+3];
    assign miss_idx       = instr_a[INDEX_WIDTH+2:3];
    assign miss_tag       = instr_a[31:INDEX_WIDTH+3];
    assign unused_pc_lsbs = ^if_pc[1:0];

    assign hit      = valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
    assign if_ready = if_valid & hit & ~rst_in;
    assign if_instr = if_pc[2] ? data_q[pc_idx][63:32] : data_q[pc_idx][31:0];

    // Request is masked on the done cycle so the controller never sees a second one.
    assign instr_signal = (state_q == MISS) & ~instr_done;
    assign fill         = (state_q == MISS) & instr_done & rdy_in;

    always_comb begin
        state_d    = state_q;
        start_miss = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_valid && !hit && !clear_signal) begin
                    state_d    = MISS;
                    start_miss = 1'b1;
                end
            end
            MISS: begin
                if (instr_done || clear_signal) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            valid_q <= '0;
            instr_a <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            if (start_miss) begin
                instr_a <= {if_pc[31:3], 3'b000};
            end
            if (fill) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_in) begin
        if (fill) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= instr_d;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: hits, misses, conflicts, flush, stall, async reset.
module tb_instr_cache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_signal;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [31:0] if_instr;
    logic        instr_signal;
    logic [31:0] instr_a;
    logic [63:0] instr_d;
    logic        instr_done;

    int vectors = 0;
    int miscompares = 0;

    instr_cache #(.INDEX_WIDTH(4)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear_signal (clear_signal),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .instr_signal (instr_signal),
        .instr_a      (instr_a),
        .instr_d      (instr_d),
        .instr_done   (instr_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0; if_valid = 1'b0;
        if_pc = 32'h0; instr_d = 64'h0; instr_done = 1'b0;
        tick(); tick();
        chk("rst_ready", {63'h0, if_ready}, 64'h0);
        chk("rst_signal", {63'h0, instr_signal}, 64'h0);
        chk("rst_addr", {32'h0, instr_a}, 64'h0);

        // 1: cold miss at 0x0, fill, then hits on both words
        rst_in = 1'b0; if_valid = 1'b1; if_pc = 32'h0;
        #1 chk("t1_cold_ready", {63'h0, if_ready}, 64'h0);
        chk("t1_no_req_yet", {63'h0, instr_signal}, 64'h0);
        tick();
        chk("t1_req", {63'h0, instr_signal}, 64'h1);
        chk("t1_addr", {32'h0, instr_a}, 64'h0);
        instr_done = 1'b1; instr_d = 64'h00000013_00100093;
        #1 chk("t4_req_low_on_done", {63'h0, instr_signal}, 64'h0);
        tick();
        instr_done = 1'b0;
        #1 chk("t1_hit_ready", {63'h0, if_ready}, 64'h1);
        chk("t1_hit_w0", {32'h0, if_instr}, 64'h00100093);
        if_pc = 32'h4;
        #1 chk("t1_hit_w1_ready", {63'h0, if_ready}, 64'h1);
        chk("t1_hit_w1", {32'h0, if_instr}, 64'h00000013);
        tick();
        chk("t1_no_req_on_hit", {63'h0, instr_signal}, 64'h0);

        // 2: conflict eviction at index 0
        if_pc = 32'h80;
        #1 chk("t2_conflict_miss", {63'h0, if_ready}, 64'h0);
        tick();
        chk("t2_req", {63'h0, instr_signal}, 64'h1);
        chk("t2_addr", {32'h0, instr_a}, 64'h80);
        instr_done = 1'b1; instr_d = 64'h11111111_22222222;
        tick();
        instr_done = 1'b0;
        #1 chk("t2_hit_80", {32'h0, if_instr}, 64'h22222222);
        chk("t2_hit_80_ready", {63'h0, if_ready}, 64'h1);
        if_pc = 32'h0;
        #1 chk("t2_evicted", {63'h0, if_ready}, 64'h0);
        tick();
        chk("t2_refetch_req", {63'h0, instr_signal}, 64'h1);
        chk("t2_refetch_addr", {32'h0, instr_a}, 64'h0);

        // 3: flush during miss, then flush in IDLE blocks a request
        clear_signal = 1'b1;
        tick();
        clear_signal = 1'b0;
        #1 chk("t3_flush_drop", {63'h0, instr_signal}, 64'h0);
        chk("t3_still_miss", {63'h0, if_ready}, 64'h0);
        tick();
        chk("t3_rerequest", {63'h0, instr_signal}, 64'h1);
        clear_signal = 1'b1;
        tick();
        tick();
        chk("t3_idle_flush_block", {63'h0, instr_signal}, 64'h0);
        clear_signal = 1'b0;

        // 5: stall mid-miss with a stray done pulse
        tick();
        chk("t5_req", {63'h0, instr_signal}, 64'h1);
        rdy_in = 1'b0; instr_done = 1'b1; instr_d = 64'hDEADBEEF_DEADBEEF; if_pc = 32'h100;
        tick();
        instr_done = 1'b0;
        #1 chk("t5_stall_req", {63'h0, instr_signal}, 64'h1);
        chk("t5_stall_addr", {32'h0, instr_a}, 64'h0);
        tick(); tick();
        chk("t5_stall_addr2", {32'h0, instr_a}, 64'h0);
        rdy_in = 1'b1; if_pc = 32'h80;
        #1 chk("t5_no_stray_fill", {32'h0, if_instr}, 64'h22222222);
        if_pc = 32'h0;
        #1 chk("t5_pc0_miss", {63'h0, if_ready}, 64'h0);
        chk("t5_resume_req", {63'h0, instr_signal}, 64'h1);
        instr_done = 1'b1; instr_d = 64'h00000013_00100093;
        tick();
        instr_done = 1'b0;
        #1 chk("t5_fill_ready", {63'h0, if_ready}, 64'h1);
        chk("t5_fill_data", {32'h0, if_instr}, 64'h00100093);

        // 4: done cycle with pc moved to a hit address
        if_pc = 32'h8;
        tick();
        chk("t4_req", {63'h0, instr_signal}, 64'h1);
        chk("t4_addr", {32'h0, instr_a}, 64'h8);
        instr_done = 1'b1; instr_d = 64'h00000033_00000073; if_pc = 32'h0;
        #1 chk("t4_done_low", {63'h0, instr_signal}, 64'h0);
        tick();
        instr_done = 1'b0;
        #1 chk("t4_no_second_req", {63'h0, instr_signal}, 64'h0);
        tick();
        chk("t4_no_second_req2", {63'h0, instr_signal}, 64'h0);
        if_pc = 32'hC;
        #1 chk("t4_line8_w1", {32'h0, if_instr}, 64'h00000033);

        // 6: async reset mid-miss
        if_pc = 32'h10;
        tick();
        chk("t6_req", {63'h0, instr_signal}, 64'h1);
        if_pc = 32'h0;
        #1 chk("t6_hit_in_miss", {63'h0, if_ready}, 64'h1);
        #1 rst_in = 1'b1;
        #1 chk("t6_rst_signal", {63'h0, instr_signal}, 64'h0);
        chk("t6_rst_ready", {63'h0, if_ready}, 64'h0);
        chk("t6_rst_addr", {32'h0, instr_a}, 64'h0);
        #1 rst_in = 1'b0;
        #1 chk("t6_lines_invalid", {63'h0, if_ready}, 64'h0);
        tick();
        chk("t6_refetch_req", {63'h0, instr_signal}, 64'h1);
        chk("t6_refetch_addr", {32'h0, instr_a}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
